// File: rtl/mfcc_frame_sequencer_if.sv
// Handshake bundle between the MFCC frame sequencer and its surroundings
// (window buffer, PCM FIFO status and the chain of frame-processing stages).
//
// Signals:
//   enable_i       permits launching new frames
//   clear_i        clears sticky flags and exits FAULT
//   frame_ready_i  window buffer holds a complete frame
//   fifo_full_i    PCM FIFO full indication
//   stage_done_i   one-cycle done pulse per stage
//   stage_start_o  one-hot, one-cycle start pulse per stage
//   start_move_o   window-advance pulse
//   busy_o         sequencer not idle
//   frame_done_o   last stage of a frame completed
//   frame_count_o  completed frames, wrapping
//   overrun_o      sticky FIFO-full-while-busy flag
//   fault_o        sequencer is in FAULT
//   fault_stage_o  index of the stage that timed out
//
// Modports: master = sequencer side, slave = environment side.
interface mfcc_frame_sequencer_if #(
  parameter int NUM_STAGES  = 5,
  parameter int COUNT_WIDTH = 16
);
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic                   enable_i;
  logic                   clear_i;
  logic                   frame_ready_i;
  logic                   fifo_full_i;
  logic [NUM_STAGES-1:0]  stage_done_i;
  logic [NUM_STAGES-1:0]  stage_start_o;
  logic                   start_move_o;
  logic                   busy_o;
  logic                   frame_done_o;
  logic [COUNT_WIDTH-1:0] frame_count_o;
  logic                   overrun_o;
  logic                   fault_o;
  logic [IDX_W-1:0]       fault_stage_o;

  modport master (
    input  enable_i, clear_i, frame_ready_i, fifo_full_i, stage_done_i,
    output stage_start_o, start_move_o, busy_o, frame_done_o, frame_count_o,
           overrun_o, fault_o, fault_stage_o
  );

  modport slave (
    output enable_i, clear_i, frame_ready_i, fifo_full_i, stage_done_i,
    input  stage_start_o, start_move_o, busy_o, frame_done_o, frame_count_o,
           overrun_o, fault_o, fault_stage_o
  );
endinterface

// File: rtl/mfcc_frame_sequencer.sv
// Per-frame scheduler for the MFCC datapath. When a full frame is available
// it starts each processing stage in order (one-cycle start pulse), waits for
// that stage's done pulse, advances the input window once the Hamming stage
// has finished, counts completed frames and flags overruns and hung stages.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mfcc_frame_sequencer_if.master handshake bundle
//
// Every output in the bundle is a flop except start_move_o, which follows
// stage_done_i[0] combinationally while stage 0 is being waited on.
module mfcc_frame_sequencer #(
  parameter int NUM_STAGES     = 5,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mfcc_frame_sequencer_if.master bus
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int EXT_W = 1 << IDX_W;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STAGES - 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE,
    S_FAULT
  } state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      stage_idx, stage_idx_nxt;
  logic [TMR_W-1:0]      timer;
  logic [EXT_W-1:0]      done_ext;
  logic                  cur_done;
  logic [NUM_STAGES-1:0] start_nxt;

  // Zero-extend so that indexing by stage_idx never leaves the vector.
  assign done_ext = EXT_W'(bus.stage_done_i);
  assign cur_done = done_ext[stage_idx];

  // The Hamming output is already latched when stage 0 reports done, so the
  // window may slide in that very cycle while later stages keep running.
  assign bus.start_move_o = (state == S_WAIT) && (stage_idx == '0) &&
                            bus.stage_done_i[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      stage_idx <= '0;
    end else begin
      state     <= state_nxt;
      stage_idx <= stage_idx_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    stage_idx_nxt = stage_idx;
    start_nxt     = '0;
    case (state)
      S_IDLE: begin
        if (bus.enable_i && bus.frame_ready_i) begin
          state_nxt     = S_LAUNCH;
          stage_idx_nxt = '0;
        end
      end
      // A done pulse in the start cycle is not looked at here.
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT: begin
        // Done is tested first so it wins over a coincident timeout.
        if (cur_done) begin
          if (stage_idx == LAST_IDX) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt     = S_LAUNCH;
            stage_idx_nxt = stage_idx + 1'b1;
          end
        end else if (timer == TMR_LIMIT) begin
          state_nxt = S_FAULT;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      S_FAULT: begin
        if (bus.clear_i) begin
          state_nxt     = S_IDLE;
          stage_idx_nxt = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (state_nxt == S_LAUNCH) begin
      start_nxt = NUM_STAGES'(1) << stage_idx_nxt;
    end
  end

  // Outputs are registered from the next-state decode so they line up with
  // the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer             <= '0;
      bus.stage_start_o <= '0;
      bus.busy_o        <= 1'b0;
      bus.frame_done_o  <= 1'b0;
      bus.frame_count_o <= '0;
      bus.overrun_o     <= 1'b0;
      bus.fault_o       <= 1'b0;
      bus.fault_stage_o <= '0;
    end else begin
      // Timer reads 0 during LAUNCH and N on the N-th cycle after the start.
      if (state_nxt == S_LAUNCH) begin
        timer <= '0;
      end else if (state == S_LAUNCH || state == S_WAIT) begin
        timer <= timer + 1'b1;
      end

      bus.stage_start_o <= start_nxt;
      bus.busy_o        <= (state_nxt != S_IDLE);
      bus.frame_done_o  <= (state_nxt == S_DONE);
      bus.fault_o       <= (state_nxt == S_FAULT);

      if (state == S_DONE) begin
        bus.frame_count_o <= bus.frame_count_o + 1'b1;
      end

      if (state == S_WAIT && state_nxt == S_FAULT) begin
        bus.fault_stage_o <= stage_idx;
      end

      // clear_i beats a same-cycle set.
      if (bus.clear_i) begin
        bus.overrun_o <= 1'b0;
      end else if (bus.fifo_full_i && state != S_IDLE && state != S_FAULT) begin
        bus.overrun_o <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mfcc_frame_sequencer.md
# mfcc_frame_sequencer

Per-frame scheduler for the MFCC datapath. It sits between the window buffer and the chain of frame-processing stages (Hamming, FFT, mel filterbank, log, DCT). When a full frame is available it launches each stage in order with a one-cycle start pulse and waits for that stage's done pulse. It also issues the window-advance command, counts completed frames, and flags overruns and hung stages.

## Interface
Parameters:
- NUM_STAGES, 5: number of sequenced stages; stage 0 is the Hamming stage.
- TIMEOUT_CYCLES, 4096: maximum cycles any stage may take between start and done.
- COUNT_WIDTH, 16: width of the frame counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable_i  in  1  permits launching new frames; sampled only in IDLE.
- clear_i  in  1  clears the sticky flags and exits FAULT.
- frame_ready_i  in  1  level from the window buffer: a complete frame is readable.
- fifo_full_i  in  1  PCM FIFO full indication, used for overrun detection.
- stage_done_i  in  NUM_STAGES  one-cycle done pulse per stage.
- stage_start_o  out  NUM_STAGES  one-hot, one-cycle start pulse per stage.
- start_move_o  out  1  one-cycle pulse telling the window buffer to slide by FRAME_MOVE.
- busy_o  out  1  high in every state except IDLE.
- frame_done_o  out  1  one-cycle pulse when the last stage completes.
- frame_count_o  out  COUNT_WIDTH  number of completed frames; wraps modulo 2^COUNT_WIDTH.
- overrun_o  out  1  sticky: FIFO became full while a frame was in flight.
- fault_o  out  1  high while in FAULT.
- fault_stage_o  out  $clog2(NUM_STAGES)  index of the stage that timed out.

## Operation
- States: IDLE, LAUNCH, WAIT, DONE, FAULT. stage_idx is a register of width $clog2(NUM_STAGES).
- IDLE:
  - If enable_i && frame_ready_i, go to LAUNCH with stage_idx=0.
  - enable_i low blocks new frames but never aborts a frame already in progress.
- LAUNCH:
  - stage_start_o[stage_idx]=1 for exactly this cycle.
  - Timeout timer cleared to 0.
  - Always goes to WAIT.
- WAIT:
  - The timer increments every cycle.
  - On stage_done_i[stage_idx]=1:
    - If stage_idx==0, assert start_move_o in that same cycle. The Hamming output is already latched, so the window may advance while later stages run.
    - If stage_idx==NUM_STAGES-1, go to DONE.
    - Otherwise increment stage_idx and go to LAUNCH.
  - done bits of non-current stages are ignored.
  - If the timer reaches TIMEOUT_CYCLES-1 with no done, go to FAULT and latch fault_stage_o=stage_idx.
  - If done and timeout occur in the same cycle, done wins.
- DONE:
  - frame_done_o=1 for one cycle; frame_count_o increments.
  - Go to IDLE.
- FAULT:
  - fault_o=1; all start pulses are suppressed.
  - Exit to IDLE only on clear_i; stage_idx resets to 0.
- Overrun:
  - overrun_o is set when fifo_full_i=1 in any state other than IDLE or FAULT.
  - It is cleared only by clear_i; clear_i has priority over setting in the same cycle.
- clear_i outside FAULT clears overrun_o only and does not change the state.
- NUM_STAGES=1: stage 0 is also the last stage. start_move_o and the DONE transition both occur on its done pulse.

## Timing
- Reset values: state IDLE, stage_idx 0, all outputs 0, frame_count_o 0.
- An asynchronous reset mid-frame returns the block to IDLE immediately. No pending pulse is emitted after reset release.
- Launch latency: frame_ready_i && enable_i sampled high in IDLE produces stage_start_o[0] on the next cycle.
- Stage-to-stage: done sampled at cycle N produces the next stage's start at cycle N+1. A stage must not assert done in its own start cycle; such a pulse is ignored.
- Last done at cycle N gives frame_done_o at N+1 and frame_count_o updated at N+2. The earliest next launch is at N+3.
- All outputs are registered. start_move_o is the only exception: it is combinational from stage_done_i[0] in WAIT with stage_idx==0.

## Test plan
- NUM_STAGES=5; each stage returns done 3 cycles after start -> start pulses at relative cycles 1, 5, 9, 13, 17; start_move_o coincides with stage 0 done; frame_done_o once; frame_count_o=1.
- frame_ready_i held high and enable_i=1 for 4 frames -> frame_count_o=4; exactly 4 start_move_o pulses; no start pulse overlaps another.
- TIMEOUT_CYCLES=16; stage 2 never responds -> fault_o rises 16 cycles after stage 2's start, fault_stage_o=2, no further starts; clear_i -> IDLE and fault_o=0.
- stage_done_i[3] pulses while stage 1 is active -> ignored; the sequence continues normally once stage 1 done arrives.
- fifo_full_i pulsed during stage 1 -> overrun_o=1 persists after the frame; clear_i -> 0. A pulse while IDLE leaves overrun_o=0.
- rst_n asserted while waiting on stage 3 -> all outputs 0 immediately; after release with frame_ready_i=1, stage_start_o[0] is the first pulse.
